// File: rtl/cpu_boot_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_boot_ctrl
//   Program-load and run controller that sits in front of cpu_top. It streams
//   a program image into instruction memory and pads the unwritten tail with
//   NOP words. It then holds the CPU in reset for RESET_HOLD cycles and
//   releases it. The run ends when the cycle budget expires or when the PC
//   stops moving (a self-loop halt).
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, starts a load from IDLE or DONE
//   load_valid/ready      program stream handshake
//   load_data, load_last  program word and end-of-image marker
//   imem_we/waddr/wdata   instruction memory write port (1-cycle latency)
//   cpu_rst               active-high reset to cpu_top
//   pc                    cpu_top program counter, watched for halts
//   busy, done            status: busy outside IDLE/DONE, done in DONE
//   halted, timed_out     reason the run ended (valid in DONE)
//   words_loaded          words accepted from the stream
//   run_count             cycles spent in RUN (saturating)
// -----------------------------------------------------------------------------
module cpu_boot_ctrl #(
  parameter int unsigned IMEM_DEPTH  = 64,
  parameter int unsigned AW          = $clog2(IMEM_DEPTH),
  parameter logic [31:0] NOP_WORD    = 32'h00000013,
  parameter int unsigned RESET_HOLD  = 2,
  parameter int unsigned RUN_CYCLES  = 70,
  parameter int unsigned HALT_WINDOW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  input  logic [31:0]   pc,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic          timed_out,
  output logic [AW:0]   words_loaded,
  output logic [31:0]   run_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_HOLD, S_RUN, S_DONE} state_t;

  // The write address is one bit wider than the memory so "memory full"
  // (address == IMEM_DEPTH) is distinguishable from address 0.
  localparam logic [AW:0] LP_FULL      = (AW+1)'(IMEM_DEPTH);
  localparam logic [AW:0] LP_LAST      = (AW+1)'(IMEM_DEPTH - 1);
  localparam logic [31:0] LP_HOLD_LAST = 32'(RESET_HOLD - 1);
  localparam logic [31:0] LP_RUN       = 32'(RUN_CYCLES);
  localparam logic [31:0] LP_HALT      = 32'(HALT_WINDOW);

  state_t        r_state, w_state;
  logic [AW:0]   r_addr, w_addr;
  logic [31:0]   r_hold, w_hold;
  logic [31:0]   r_halt_cnt, w_halt_cnt;
  logic [31:0]   r_prev_pc, w_prev_pc;
  logic          r_pc_vld, w_pc_vld;
  logic          r_load_ready, w_load_ready;
  logic          r_we, w_we;
  logic [AW-1:0] r_waddr, w_waddr;
  logic [31:0]   r_wdata, w_wdata;
  logic          r_cpu_rst, w_cpu_rst;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_halted, w_halted;
  logic          r_timed_out, w_timed_out;
  logic [AW:0]   r_words, w_words;
  logic [31:0]   r_run_count, w_run_count;

  logic          w_accept;
  logic [31:0]   w_run_inc;
  logic [31:0]   w_halt_inc;
  logic          w_time_hit;
  logic          w_halt_hit;

  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_hold       = r_hold;
    w_halt_cnt   = r_halt_cnt;
    w_prev_pc    = r_prev_pc;
    w_pc_vld     = r_pc_vld;
    w_load_ready = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_waddr;
    w_wdata      = r_wdata;
    w_cpu_rst    = 1'b1;
    w_halted     = r_halted;
    w_timed_out  = r_timed_out;
    w_words      = r_words;
    w_run_count  = r_run_count;

    w_accept   = load_valid & r_load_ready;
    w_run_inc  = (&r_run_count) ? r_run_count : r_run_count + 32'd1;
    // The first RUN cycle has no previous pc to compare against.
    w_halt_inc = (r_pc_vld && (pc == r_prev_pc)) ? r_halt_cnt + 32'd1 : 32'd0;
    w_time_hit = (RUN_CYCLES != 0) && (w_run_inc == LP_RUN);
    w_halt_hit = (HALT_WINDOW != 0) && (w_halt_inc == LP_HALT);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state      = S_LOAD;
          w_addr       = '0;
          w_words      = '0;
          w_run_count  = '0;
          w_halted     = 1'b0;
          w_timed_out  = 1'b0;
          w_load_ready = 1'b1;
        end
      end
      S_LOAD: begin
        w_load_ready = 1'b1;
        if (w_accept) begin
          w_we    = 1'b1;
          w_waddr = r_addr[AW-1:0];
          w_wdata = load_data;
          w_addr  = r_addr + 1'b1;
          w_words = r_words + 1'b1;
          if (load_last || (r_addr == LP_LAST)) begin
            w_state      = S_FILL;
            w_load_ready = 1'b0;
          end
        end
      end
      S_FILL: begin
        w_hold = '0;
        if (r_addr == LP_FULL) begin
          w_state = S_HOLD;
        end else begin
          w_we    = 1'b1;
          w_waddr = r_addr[AW-1:0];
          w_wdata = NOP_WORD;
          w_addr  = r_addr + 1'b1;
          if (r_addr == LP_LAST) w_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold == LP_HOLD_LAST) begin
          w_state    = S_RUN;
          w_cpu_rst  = 1'b0;
          w_halt_cnt = '0;
          w_pc_vld   = 1'b0;
        end else begin
          w_hold = r_hold + 32'd1;
        end
      end
      S_RUN: begin
        w_cpu_rst   = 1'b0;
        w_run_count = w_run_inc;
        w_halt_cnt  = w_halt_inc;
        w_prev_pc   = pc;
        w_pc_vld    = 1'b1;
        if (w_time_hit || w_halt_hit) begin
          w_state     = S_DONE;
          w_cpu_rst   = 1'b1;
          w_timed_out = w_time_hit;
          w_halted    = w_halt_hit;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE) && (w_state != S_DONE);
    w_done = (w_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_hold       <= '0;
      r_halt_cnt   <= '0;
      r_pc_vld     <= 1'b0;
      r_load_ready <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_halted     <= 1'b0;
      r_timed_out  <= 1'b0;
      r_words      <= '0;
      r_run_count  <= '0;
    end else begin
      r_state      <= w_state;
      r_addr       <= w_addr;
      r_hold       <= w_hold;
      r_halt_cnt   <= w_halt_cnt;
      r_pc_vld     <= w_pc_vld;
      r_load_ready <= w_load_ready;
      r_we         <= w_we;
      r_waddr      <= w_waddr;
      r_cpu_rst    <= w_cpu_rst;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_halted     <= w_halted;
      r_timed_out  <= w_timed_out;
      r_words      <= w_words;
      r_run_count  <= w_run_count;
    end
  end

  // Data-only registers: qualified by imem_we / r_pc_vld, so no reset needed.
  always_ff @(posedge clk) begin
    r_wdata   <= w_wdata;
    r_prev_pc <= w_prev_pc;
  end

  assign load_ready   = r_load_ready;
  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign halted       = r_halted;
  assign timed_out    = r_timed_out;
  assign words_loaded = r_words;
  assign run_count    = r_run_count;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_boot_ctrl
//   Self-checking bench for cpu_boot_ctrl (IMEM_DEPTH=64, RESET_HOLD=2,
//   RUN_CYCLES=70, HALT_WINDOW=4). Each task drives one scenario and checks
//   the DUT against expectations computed from the program image, the
//   accept times and the pc history.
// -----------------------------------------------------------------------------
module tb_cpu_boot_ctrl;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n, start, load_valid, load_ready, load_last;
  logic [31:0] load_data;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic [31:0] pc;
  logic        busy, done, halted, timed_out;
  logic [6:0]  words_loaded;
  logic [31:0] run_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] prog[$];
  int          wl_cyc[$];
  int          wl_addr[$];
  logic [31:0] wl_data[$];

  cpu_boot_ctrl #(
    .IMEM_DEPTH(64), .NOP_WORD(32'h00000013), .RESET_HOLD(2),
    .RUN_CYCLES(70), .HALT_WINDOW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .pc(pc), .busy(busy), .done(done), .halted(halted),
    .timed_out(timed_out), .words_loaded(words_loaded), .run_count(run_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log: every memory write with the cycle (edge count) it appeared at.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wl_cyc.push_back(cyc);
      wl_addr.push_back(int'(imem_waddr));
      wl_data.push_back(imem_wdata);
    end
  end

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic make_alu_prog;
    prog.delete();
    prog = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h40208233,
             32'h0020f2b3, 32'h0020e333, 32'h0020c3b3, 32'h00302023,
             32'h00002403, 32'h00340463, 32'h00100493, 32'h00200513,
             32'h008000ef, 32'h00300593, 32'h0000006f};
  endtask

  // Loads n words of prog, optionally with load_last, gaps and start pokes,
  // then waits for the CPU release and checks the full write sequence.
  task automatic load_and_check(input int n, input bit use_last, input bit toggle, input bit poke);
    int exp_acc, idx, guard, j, fall_cyc, last_acc, fill_end, exp_cyc;
    int acc_cyc[$];
    bit acc;
    logic [31:0] exp_data;
    exp_acc = use_last ? n : ((n < DEPTH) ? n : DEPTH);
    wl_cyc.delete(); wl_addr.delete(); wl_data.delete();
    do_start();
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL start_ready: got %b want 1", load_ready); end
    total++; if (words_loaded !== 7'd0) begin bad++; $display("FAIL start_words_clear: got %0d want 0", words_loaded); end
    total++; if (run_count !== 32'd0) begin bad++; $display("FAIL start_run_clear: got %0d want 0", run_count); end
    total++; if ({done, halted, timed_out} !== 3'b000) begin bad++; $display("FAIL start_flags_clear: got %b want 000", {done, halted, timed_out}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end

    idx = 0; guard = 0;
    while (idx < exp_acc && guard < 1000) begin
      load_valid = !toggle || (guard % 2 == 0);
      load_data  = prog[idx];
      load_last  = use_last && (idx == n - 1);
      start      = poke && (guard % 4 == 3);
      acc        = load_valid && load_ready;
      @(posedge clk); #1; guard++;
      start = 1'b0;
      if (acc) begin acc_cyc.push_back(cyc); idx++; end
    end
    total++; if (idx != exp_acc) begin bad++; $display("FAIL accept_count: got %0d want %0d", idx, exp_acc); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ready_drop: got %b want 0", load_ready); end

    // Keep offering any remaining words until the CPU is released.
    j = idx; guard = 0;
    while (cpu_rst !== 1'b0 && guard < 300) begin
      load_valid = (j < n);
      load_last  = 1'b0;
      if (j < n) load_data = prog[j];
      @(posedge clk); #1; guard++; j++;
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL ready_low: got %b want 0 at cycle %0d", load_ready, cyc); end
    end
    load_valid = 1'b0;
    fall_cyc = cyc;
    total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL run_entry: cpu_rst=%b want 0 within 300 cycles", cpu_rst); end

    last_acc = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size() - 1] : 0;
    fill_end = (exp_acc < DEPTH) ? last_acc + (DEPTH - exp_acc) : last_acc + 1;
    total++; if (fall_cyc != fill_end + 2) begin bad++; $display("FAIL cpu_rst_release: cycle %0d want %0d", fall_cyc, fill_end + 2); end
    total++; if (wl_cyc.size() != DEPTH) begin bad++; $display("FAIL write_count: got %0d want %0d", wl_cyc.size(), DEPTH); end
    for (int i = 0; i < wl_cyc.size() && i < DEPTH; i++) begin
      if (i < exp_acc) begin
        exp_data = prog[i];
        exp_cyc  = (i < acc_cyc.size()) ? acc_cyc[i] : -1;
      end else begin
        exp_data = NOP;
        exp_cyc  = last_acc + (i - exp_acc + 1);
      end
      total++;
      if (wl_addr[i] != i || wl_data[i] !== exp_data || wl_cyc[i] != exp_cyc) begin
        bad++;
        $display("FAIL write[%0d]: addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 i, wl_addr[i], wl_data[i], wl_cyc[i], i, exp_data, exp_cyc);
        break;
      end
    end
    total++; if (words_loaded !== 7'(exp_acc)) begin bad++; $display("FAIL words_loaded: got %0d want %0d", words_loaded, exp_acc); end
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL run_status: busy=%b done=%b want 1/0", busy, done); end
  endtask

  // mode 0: pc always moves; 1: pc settles at a random cycle;
  // 2: random pc; 3: pc settles so halt and budget coincide.
  task automatic run_and_check(input int mode);
    logic [31:0] hist[$];
    logic [31:0] base, p;
    int k, s;
    bit exp_done, exp_halt, exp_to;
    base = $urandom & 32'h0000fffc;
    s = (mode == 1) ? int'($urandom_range(5, 40)) : 66;
    k = 0; exp_done = 0; exp_halt = 0; exp_to = 0;
    while (!exp_done && k < 200) begin
      case (mode)
        0:       p = base + 32'(4 * k);
        2:       p = base + 32'(4 * $urandom_range(0, 1));
        default: p = (k + 1 < s) ? base + 32'(4 * (k + 1)) : base + 32'(4 * s);
      endcase
      pc = p; hist.push_back(p);
      @(posedge clk); #1; k++;
      // Halt: pc unchanged over the last HALT_WINDOW (4) cycle pairs in RUN.
      exp_halt = 0;
      if (hist.size() >= 5) begin
        exp_halt = 1;
        for (int j = 1; j < 5; j++)
          if (hist[hist.size() - 1 - j] != hist[hist.size() - 1]) exp_halt = 0;
      end
      exp_to   = (k == 70);
      exp_done = exp_halt || exp_to;
      total++; if (run_count !== 32'(k)) begin bad++; $display("FAIL run_count: got %0d want %0d", run_count, k); end
      total++;
      if (done !== exp_done || cpu_rst !== exp_done) begin
        bad++; $display("FAIL run_state at run cycle %0d: done=%b cpu_rst=%b want %b", k, done, cpu_rst, exp_done);
        break;
      end
    end
    total++; if (halted !== exp_halt || timed_out !== exp_to) begin bad++; $display("FAIL run_flags: halted=%b timed_out=%b want %b %b", halted, timed_out, exp_halt, exp_to); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      pc = $urandom;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || cpu_rst !== 1'b1 || run_count !== 32'(k) || halted !== exp_halt || timed_out !== exp_to) begin
        bad++; $display("FAIL done_hold: done=%b cpu_rst=%b run_count=%0d flags=%b%b want 1 1 %0d %b%b",
                        done, cpu_rst, run_count, halted, timed_out, k, exp_halt, exp_to);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL %s cpu_rst: got %b want 1", tag, cpu_rst); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL %s imem_we: got %b want 0", tag, imem_we); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL %s load_ready: got %b want 0", tag, load_ready); end
    total++; if ({busy, done, halted, timed_out} !== 4'b0000) begin bad++; $display("FAIL %s status: got %b want 0000", tag, {busy, done, halted, timed_out}); end
    total++; if (words_loaded !== 7'd0 || run_count !== 32'd0) begin bad++; $display("FAIL %s counters: words=%0d run=%0d want 0 0", tag, words_loaded, run_count); end
    total++; if (imem_waddr !== 6'd0) begin bad++; $display("FAIL %s waddr: got %0d want 0", tag, imem_waddr); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || cpu_rst !== 1'b1 || load_ready !== 1'b0) begin bad++; $display("FAIL idle_hold: busy=%b cpu_rst=%b ready=%b want 0 1 0", busy, cpu_rst, load_ready); end
  endtask

  task automatic test_load_timeout;
    make_alu_prog();
    load_and_check(15, 1'b1, 1'b0, 1'b0);
    run_and_check(0);
  endtask

  task automatic test_halt;
    prog.delete();
    for (int i = 0; i < 9; i++) prog.push_back($urandom);
    prog.push_back(32'h0000006f);
    load_and_check(10, 1'b1, 1'b0, 1'b0);
    run_and_check(1);
  endtask

  task automatic test_overflow;
    prog.delete();
    for (int i = 0; i < 70; i++) prog.push_back($urandom);
    load_and_check(70, 1'b0, 1'b0, 1'b0);
    run_and_check(2);
  endtask

  task automatic test_toggle_start;
    make_alu_prog();
    load_and_check(15, 1'b1, 1'b1, 1'b1);
    run_and_check(3);
  endtask

  task automatic test_reset_mid_run;
    make_alu_prog();
    load_and_check(15, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      pc = 32'(4 * i);
      @(posedge clk); #1;
    end
    total++; if (run_count !== 32'd10) begin bad++; $display("FAIL mid_run_count: got %0d want 10", run_count); end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("mid_run_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_load;
    prog.delete();
    for (int i = 0; i < 15; i++) prog.push_back($urandom);
    do_start();
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (words_loaded !== 7'd5 || imem_we !== 1'b1) begin bad++; $display("FAIL mid_load_progress: words=%0d we=%b want 5 1", words_loaded, imem_we); end
    #2 rst_n = 1'b0; load_valid = 1'b0;
    #1;
    check_reset_values("mid_load_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || load_ready !== 1'b0) begin bad++; $display("FAIL post_reset_idle: busy=%b ready=%b want 0 0", busy, load_ready); end
    load_and_check(15, 1'b1, 1'b0, 1'b0);
    run_and_check(1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; pc = '0;
    test_reset();
    test_load_timeout();
    test_halt();
    test_overflow();
    test_toggle_start();
    test_reset_mid_run();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
